// File: rtl/sram_dp_be_if.sv
// sram_dp_be_if: request/response bundle for the dual-port byte-enable SRAM.
// master drives requests and clear, slave returns read data and status.
interface sram_dp_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                      clear;
   logic                      wr_en;
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic [DATA_WIDTH/8-1:0]   wr_be;
   logic                      rd_en;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0]     rd_data;
   logic                      rd_valid;
   logic                      collision;
   logic                      init_done;

   modport master (
      output clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, collision, init_done
   );

   modport slave (
      input  clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, collision, init_done
   );
endinterface

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple dual-port SRAM with byte enables, 1/2-cycle read
// latency, selectable read-during-write policy and an init sweep.
module sram_dp_be #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 4,
   parameter int                    RD_LAT      = 1,
   parameter int                    WRITE_FIRST = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic        clk,
   input  logic        reset,
   sram_dp_be_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;

   typedef enum logic {INIT, RUN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  sweep_we;
   logic                  usr_wr;
   logic                  usr_rd;
   logic                  hit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  s1_v;
   logic                  s1_c;
   logic [DATA_WIDTH-1:0] s1_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // clear outranks both the sweep and any user request
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sweep_we = 1'b0;
      usr_wr   = 1'b0;
      usr_rd   = 1'b0;
      if (bus.clear) begin
         state_d = INIT;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            INIT: begin
               sweep_we = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == ADDR_WIDTH'(DEPTH - 1))
                  state_d = RUN;
            end
            RUN: begin
               usr_wr = bus.wr_en;
               usr_rd = bus.rd_en;
            end
            default: state_d = INIT;
         endcase
      end
   end

   // the array itself is never reset; a write on a reset edge is dropped
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (sweep_we) begin
            mem[cnt_q] <= INIT_VALUE;
         end else if (usr_wr) begin
            for (int b = 0; b < NB; b++)
               if (bus.wr_be[b])
                  mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
         end
      end
   end

   assign hit = usr_wr && (bus.wr_addr == bus.rd_addr);

   always_comb begin
      rd_word = mem[bus.rd_addr];
      if (hit && (WRITE_FIRST != 0))
         for (int b = 0; b < NB; b++)
            if (bus.wr_be[b])
               rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v <= 1'b0;
         s1_c <= 1'b0;
         s1_d <= '0;
      end else begin
         s1_v <= usr_rd;
         s1_c <= usr_rd && hit;
         if (usr_rd)
            s1_d <= rd_word;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic                  s2_v;
      logic                  s2_c;
      logic [DATA_WIDTH-1:0] s2_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s2_v <= 1'b0;
            s2_c <= 1'b0;
            s2_d <= '0;
         end else begin
            s2_v <= s1_v;
            s2_c <= s1_c;
            if (s1_v)
               s2_d <= s1_d;
         end
      end

      assign bus.rd_valid  = s2_v;
      assign bus.collision = s2_c;
      assign bus.rd_data   = s2_d;
   end else begin : g_lat1
      assign bus.rd_valid  = s1_v;
      assign bus.collision = s1_c;
      assign bus.rd_data   = s1_d;
   end

   assign bus.init_done = (state_q == RUN);
endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: two builds (lat1/write-first, lat2/read-first) driven in
// lockstep and checked against a word-array model plus literal expectations.
module tb_sram_dp_be;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   sram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia ();
   sram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib ();

   assign ib.clear   = ia.clear;
   assign ib.wr_en   = ia.wr_en;
   assign ib.wr_addr = ia.wr_addr;
   assign ib.wr_data = ia.wr_data;
   assign ib.wr_be   = ia.wr_be;
   assign ib.rd_en   = ia.rd_en;
   assign ib.rd_addr = ia.rd_addr;

   sram_dp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LAT(1),
      .WRITE_FIRST(1), .INIT_VALUE(32'hA5A5_A5A5)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(ia.slave)
   );

   sram_dp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LAT(2),
      .WRITE_FIRST(0), .INIT_VALUE(32'h3C3C_0F0F)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(ib.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat(int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] initv(int i);
      return (i == 0) ? 32'hA5A5_A5A5 : 32'h3C3C_0F0F;
   endfunction

   // {rd_valid, collision, init_done, rd_data}
   function automatic logic [34:0] dout(int i);
      if (i == 0)
         return {ia.rd_valid, ia.collision, ia.init_done, ia.rd_data};
      return {ib.rd_valid, ib.collision, ib.init_done, ib.rd_data};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // model: word array, sweep progress and expected-output ring per build
   logic [31:0] mm   [2][16];
   bit          run  [2];
   int          cnt  [2];
   bit          ev   [2][64];
   bit          ec   [2][64];
   logic [31:0] ed   [2][64];
   logic [31:0] hold [2];
   int          ecnt;

   task automatic model_edge(input int i);
      int          slot;
      logic [31:0] old;
      bit          h;
      slot = (ecnt + lat(i) - 1) % 64;
      ev[i][slot] = 1'b0;
      ec[i][slot] = 1'b0;
      if (ia.clear) begin
         run[i] = 1'b0;
         cnt[i] = 0;
      end else if (!run[i]) begin
         mm[i][cnt[i]] = initv(i);
         if (cnt[i] == 15)
            run[i] = 1'b1;
         cnt[i] = (cnt[i] + 1) % 16;
      end else begin
         old = mm[i][ia.rd_addr];
         h   = ia.wr_en && (ia.wr_addr == ia.rd_addr);
         if (ia.wr_en)
            for (int b = 0; b < 4; b++)
               if (ia.wr_be[b])
                  mm[i][ia.wr_addr][8*b +: 8] = ia.wr_data[8*b +: 8];
         if (ia.rd_en) begin
            ev[i][slot] = 1'b1;
            ec[i][slot] = h;
            ed[i][slot] = (h && i == 0) ? mm[i][ia.rd_addr] : old;
         end
      end
   endtask

   initial begin
      ecnt = 0;
      for (int i = 0; i < 2; i++) begin
         run[i]  = 1'b0;
         cnt[i]  = 0;
         hold[i] = '0;
         for (int s = 0; s < 64; s++) begin
            ev[i][s] = 1'b0;
            ec[i][s] = 1'b0;
            ed[i][s] = '0;
         end
      end
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < 2; i++) begin
               run[i]  = 1'b0;
               cnt[i]  = 0;
               hold[i] = '0;
               for (int s = 0; s < 64; s++)
                  ev[i][s] = 1'b0;
            end
         end else begin
            for (int i = 0; i < 2; i++)
               model_edge(i);
            ecnt = ecnt + 1;
         end
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            int          s;
            logic [34:0] o;
            s = (ecnt + 63) % 64;
            o = dout(i);
            if (!reset && ev[i][s])
               hold[i] = ed[i][s];
            tests++;
            if (o[34] !== (!reset && ev[i][s]) ||
                o[33] !== (!reset && ev[i][s] && ec[i][s]) ||
                o[32] !== run[i] ||
                o[31:0] !== hold[i]) begin
               fails++;
               $display("FAIL model[%0d] t=%0t: got v%b c%b d%b %h expected v%b c%b d%b %h",
                        i, $time, o[34], o[33], o[32], o[31:0],
                        ev[i][s], ev[i][s] && ec[i][s], run[i], hold[i]);
            end
         end
      end
   end

   task automatic idle_inputs();
      ia.clear   = 1'b0;
      ia.wr_en   = 1'b0;
      ia.wr_addr = '0;
      ia.wr_data = '0;
      ia.wr_be   = '0;
      ia.rd_en   = 1'b0;
      ia.rd_addr = '0;
   endtask

   task automatic drive(input bit clr, input bit we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit re, input logic [3:0] ra);
      ia.clear   = clr;
      ia.wr_en   = we;
      ia.wr_addr = wa;
      ia.wr_data = wd;
      ia.wr_be   = be;
      ia.rd_en   = re;
      ia.rd_addr = ra;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      idle_inputs();
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_a_data", ia.rd_data, 32'h0);
      chk("rst_a_valid", 32'(ia.rd_valid), 32'h0);
      chk("rst_a_done", 32'(ia.init_done), 32'h0);
      chk("rst_b_coll", 32'(ib.collision), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // init sweep lasts exactly 16 edges
      idle(15);
      chk("init15_a", 32'(ia.init_done), 32'h0);
      idle(1);
      chk("init16_a", 32'(ia.init_done), 32'h1);
      chk("init16_b", 32'(ib.init_done), 32'h1);

      drive(0, 0, 0, 0, 0, 1, 4'd0);
      chk("rd0_a_valid", 32'(ia.rd_valid), 32'h1);
      chk("rd0_a_data", ia.rd_data, 32'hA5A5_A5A5);
      for (int a = 1; a < 16; a++)
         drive(0, 0, 0, 0, 0, 1, 4'(a));
      idle(2);

      // byte-enable merge
      drive(0, 1, 4'd3, 32'h1122_3344, 4'hF, 0, 0);
      drive(0, 1, 4'd3, 32'hFFFF_FFFF, 4'b0101, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 4'd3);
      chk("be_a", ia.rd_data, 32'h11FF_33FF);
      idle(1);
      chk("be_b", ib.rd_data, 32'h11FF_33FF);
      chk("be_b_valid", 32'(ib.rd_valid), 32'h1);

      // back-to-back reads, latency 1 vs 2
      drive(0, 1, 4'd5, 32'h5555_0005, 4'hF, 0, 0);
      drive(0, 1, 4'd6, 32'h6666_0006, 4'hF, 0, 0);
      drive(0, 1, 4'd7, 32'h7777_0007, 4'hF, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 4'd5);
      chk("b2b_a5", ia.rd_data, 32'h5555_0005);
      chk("b2b_b_wait", 32'(ib.rd_valid), 32'h0);
      drive(0, 0, 0, 0, 0, 1, 4'd6);
      chk("b2b_a6", ia.rd_data, 32'h6666_0006);
      chk("b2b_b5", ib.rd_data, 32'h5555_0005);
      drive(0, 0, 0, 0, 0, 1, 4'd7);
      chk("b2b_a7", ia.rd_data, 32'h7777_0007);
      chk("b2b_b6", ib.rd_data, 32'h6666_0006);
      idle(1);
      chk("b2b_a_end", 32'(ia.rd_valid), 32'h0);
      chk("b2b_b7", ib.rd_data, 32'h7777_0007);
      idle(1);

      // same-address read during write
      drive(0, 1, 4'd9, 32'h0, 4'hF, 0, 0);
      drive(0, 1, 4'd9, 32'hDEAD_BEEF, 4'hF, 1, 4'd9);
      chk("rdw_a_data", ia.rd_data, 32'hDEAD_BEEF);
      chk("rdw_a_coll", 32'(ia.collision), 32'h1);
      idle(1);
      chk("rdw_b_data", ib.rd_data, 32'h0);
      chk("rdw_b_coll", 32'(ib.collision), 32'h1);
      drive(0, 0, 0, 0, 0, 1, 4'd9);
      idle(2);

      // clear with requests during the sweep; in-flight lat2 read completes
      drive(0, 0, 0, 0, 0, 1, 4'd3);
      drive(1, 1, 4'd2, 32'h1234_5678, 4'hF, 1, 4'd2);
      chk("clr_a_done", 32'(ia.init_done), 32'h0);
      chk("clr_a_drop", 32'(ia.rd_valid), 32'h0);
      chk("clr_b_inflight", ib.rd_data, 32'h11FF_33FF);
      for (int k = 0; k < 15; k++)
         drive(0, 1, 4'(k), 32'hCAFE_0000 | 32'(k), 4'hF, 1, 4'(15 - k));
      chk("clr_15_done", 32'(ia.init_done), 32'h0);
      drive(0, 1, 4'd1, 32'hBAD0_BAD0, 4'hF, 1, 4'd1);
      chk("clr_16_done", 32'(ia.init_done), 32'h1);
      for (int a = 0; a < 16; a++)
         drive(0, 0, 0, 0, 0, 1, 4'(a));
      chk("clr_a15", ia.rd_data, 32'hA5A5_A5A5);
      idle(1);
      chk("clr_b15", ib.rd_data, 32'h3C3C_0F0F);
      idle(1);

      // reset while a lat2 read is in flight
      drive(0, 0, 0, 0, 0, 1, 4'd4);
      #1 reset = 1'b1;
      #1;
      chk("rrd_a_valid", 32'(ia.rd_valid), 32'h0);
      chk("rrd_a_data", ia.rd_data, 32'h0);
      chk("rrd_b_data", ib.rd_data, 32'h0);
      chk("rrd_b_done", 32'(ib.init_done), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      chk("rrd_b_lost", 32'(ib.rd_valid), 32'h0);
      idle(6);

      // reset mid-sweep with counter at 7; sweep restarts from 0
      #1 reset = 1'b1;
      #1;
      chk("rsw_done", 32'(ia.init_done), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(15);
      chk("rsw_15", 32'(ib.init_done), 32'h0);
      idle(1);
      chk("rsw_16", 32'(ib.init_done), 32'h1);
      drive(0, 0, 0, 0, 0, 1, 4'd0);
      drive(0, 0, 0, 0, 0, 1, 4'd15);
      chk("rsw_a15", ia.rd_data, 32'hA5A5_A5A5);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
